// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - burst read/write initiator for a generic_mem instance
//
// Accepts read or write burst commands and drives the memory ports. Write beats
// stream in over wdata_*. Read beats stream out over rsp_* under backpressure.
// The memory's one-cycle registered read latency is absorbed internally.
//
// Optional feature macro: MEM_ACCESS_WRITE_VERIFY_EN
//   When defined, every written beat is read back and compared with the data
//   that was written. A mismatch sets the sticky verify_err_o flag.
//   When undefined, verify_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o       command handshake
//   cmd_write_i                     1 = write burst, 0 = read burst
//   cmd_addr_i, cmd_len_i           start address, beats minus 1 (saturated to DEPTH-1)
//   wdata_valid_i / wdata_ready_o   write beat handshake
//   wdata_i                         write beat data
//   rsp_valid_o / rsp_ready_i       read beat handshake
//   rsp_data_o                      read beat data
//   cmd_done_o                      one-cycle pulse after the burst completes
//   verify_err_o                    sticky write-verify mismatch, cleared on command accept
//   mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o   memory write port
//   mem_rd_en_o, mem_rd_addr_o, mem_rd_data_i   memory read port (data one cycle after enable)
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [AWIDTH-1:0] cmd_addr_i,
  input  logic [AWIDTH-1:0] cmd_len_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WIDTH-1:0]  rsp_data_o,
  output logic              cmd_done_o,
  output logic              verify_err_o,
  output logic              mem_wr_en_o,
  output logic [AWIDTH-1:0] mem_wr_addr_o,
  output logic [WIDTH-1:0]  mem_wr_data_o,
  output logic              mem_rd_en_o,
  output logic [AWIDTH-1:0] mem_rd_addr_o,
  input  logic [WIDTH-1:0]  mem_rd_data_i
);

  // One extra bit so a full-depth burst (DEPTH beats) fits in the beat counters.
  localparam int CW = AWIDTH + 1;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WVRD,
    S_WVCMP
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]     iss_q, iss_d;   // beats still to write, or reads still to issue
  logic [CW-1:0]     rsp_q, rsp_d;   // read beats still to hand over
  logic              rsp_valid_q, rsp_valid_d;
  logic              done_q, done_d;
  logic              rd_issue, rd_hs;
  logic [AWIDTH-1:0] len_sat;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
  logic [WIDTH-1:0]  vdata_q, vdata_d;
  logic              err_q, err_d;
`endif

  // Wrap explicitly so non-power-of-two depths also roll over to 0.
  function automatic logic [AWIDTH-1:0] addr_inc(input logic [AWIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AWIDTH'(1);
  endfunction

  assign len_sat = (cmd_len_i > LAST_ADDR) ? LAST_ADDR : cmd_len_i;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    iss_d         = iss_q;
    rsp_d         = rsp_q;
    rsp_valid_d   = rsp_valid_q;
    done_d        = 1'b0;
    rd_issue      = 1'b0;
    rd_hs         = 1'b0;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
    vdata_d       = vdata_q;
    err_d         = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d      = cmd_addr_i;
          iss_d       = CW'(len_sat) + CW'(1);
          rsp_d       = CW'(len_sat) + CW'(1);
          rsp_valid_d = 1'b0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
          err_d       = 1'b0;
`endif
          state_d     = cmd_write_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          mem_wr_en_o   = 1'b1;
          mem_wr_addr_o = addr_q;
          mem_wr_data_o = wdata_i;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
          // Address and count advance only after the read-back compare.
          vdata_d = wdata_i;
          state_d = S_WVRD;
`else
          addr_d  = addr_inc(addr_q);
          iss_d   = iss_q - CW'(1);
          if (iss_q == CW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
      S_WVRD: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = addr_q;
        state_d       = S_WVCMP;
      end
      S_WVCMP: begin
        if (mem_rd_data_i != vdata_q) err_d = 1'b1;
        addr_d = addr_inc(addr_q);
        iss_d  = iss_q - CW'(1);
        if (iss_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end
`endif
      S_READ: begin
        // Issue only when the output slot is empty or being emptied this cycle,
        // so the memory's held read data stays stable during a stall.
        rd_issue = (iss_q != '0) && (!rsp_valid_q || rsp_ready_i);
        rd_hs    = rsp_valid_q && rsp_ready_i;
        if (rd_issue) begin
          mem_rd_en_o   = 1'b1;
          mem_rd_addr_o = addr_q;
          addr_d        = addr_inc(addr_q);
          iss_d         = iss_q - CW'(1);
          rsp_valid_d   = 1'b1;
        end else if (rd_hs) begin
          rsp_valid_d = 1'b0;
        end
        if (rd_hs) begin
          rsp_d = rsp_q - CW'(1);
          if (rsp_q == CW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      iss_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
      vdata_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_q       <= iss_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
      vdata_q     <= vdata_d;
      err_q       <= err_d;
`endif
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  // Gated so verify read-backs never appear on the response port.
  assign rsp_data_o  = rsp_valid_q ? mem_rd_data_i : '0;
  assign cmd_done_o  = done_q;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
  assign verify_err_o = err_q;
`else
  assign verify_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a registered-read memory
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 32;
  localparam int AWIDTH = $clog2(DEPTH);

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [AWIDTH-1:0] cmd_addr, cmd_len;
  logic              wdata_valid, wdata_ready;
  logic [WIDTH-1:0]  wdata;
  logic              rsp_valid, rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              cmd_done, verify_err;
  logic              mem_wr_en, mem_rd_en;
  logic [AWIDTH-1:0] mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0]  mem_wr_data, mem_rd_q;

  logic [WIDTH-1:0]  mem_arr [DEPTH];
  logic [WIDTH-1:0]  ref_mem [DEPTH];
  logic [WIDTH-1:0]  wbuf    [DEPTH];
  bit                corrupt;
  int                errors = 0;
  int                checks = 0;

  mem_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .cmd_done_o(cmd_done), .verify_err_o(verify_err),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: registered read, data held until the next read enable.
  // 'corrupt' flips bit 0 of read data to emulate a bad cell.
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_q <= mem_arr[mem_rd_addr] ^ {{(WIDTH-1){1'b0}}, corrupt};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (mem_wr_en || mem_rd_en) check_eq("wr_rd_exclusive", 64'(mem_wr_en & mem_rd_en), 64'd0);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic accept(input bit wr, input int a, input int len);
    bit ok;
    logic r;
    ok = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = AWIDTH'(a); cmd_len = AWIDTH'(len);
    for (int t = 0; t < 20; t++) begin
      settle(); r = cmd_ready; step();
      if (r) begin ok = 1; break; end
    end
    check_eq("cmd_accept", 64'(ok), 64'd1);
    cmd_valid = 1'b0;
  endtask

  // Optional hold: keep a read command offered through the whole write burst.
  task automatic do_write(input int a, input int len, input bit vrand,
                          input bit hold, input int ha, input int hl);
    int beat, cyc;
    accept(1'b1, a, len);
    if (hold) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AWIDTH'(ha); cmd_len = AWIDTH'(hl);
    end
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 200) begin
      wdata_valid = vrand ? ($urandom_range(3) != 0) : 1'b1;
      wdata = wbuf[beat];
      settle();
`ifndef MEM_ACCESS_WRITE_VERIFY_EN
      check_eq("wr_ready", 64'(wdata_ready), 64'd1);
      check_eq("wr_no_rd", 64'(mem_rd_en), 64'd0);
`endif
      if (hold) check_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("wr_done_early", 64'(cmd_done), 64'd0);
      if (wdata_valid && wdata_ready) begin
        check_eq("wr_en", 64'(mem_wr_en), 64'd1);
        check_eq("wr_addr", 64'(mem_wr_addr), 64'((a + beat) % DEPTH));
        check_eq("wr_data", 64'(mem_wr_data), 64'(wbuf[beat]));
        ref_mem[(a + beat) % DEPTH] = wbuf[beat];
        beat++;
      end else begin
        check_eq("wr_idle_en", 64'(mem_wr_en), 64'd0);
      end
      step(); cyc++;
    end
    wdata_valid = 1'b0;
    check_eq("wr_budget", 64'(cyc < 200), 64'd1);
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
    repeat (2) begin
      settle();
      check_eq("wv_done_early", 64'(cmd_done), 64'd0);
      check_eq("wv_no_rsp", 64'(rsp_valid), 64'd0);
      if (hold) check_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
    end
`endif
    settle();
    check_eq("wr_done", 64'(cmd_done), 64'd1);
    check_eq("done_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    if (hold) cmd_valid = 1'b0;
    else begin
      settle(); check_eq("wr_done_pulse", 64'(cmd_done), 64'd0); step();
    end
  endtask

  // mode 0: rsp_ready always 1; 1: pattern 1,0,0,1; 2: random
  task automatic do_read(input int a, input int len, input int mode, input bit pre);
    int got, issued, cyc, p;
    bit prev_stall;
    logic [WIDTH-1:0] prev_data;
    if (!pre) accept(1'b0, a, len);
    got = 0; issued = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    while (got <= len && cyc < 300) begin
      p = cyc % 4;
      rsp_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (p == 0 || p == 3) : 1'($urandom_range(1));
      settle();
      if (cyc == 0) begin
        check_eq("rd_lat0", 64'(rsp_valid), 64'd0);
        check_eq("rd_err_cleared", 64'(verify_err), 64'd0);
      end
      if (cyc == 1) check_eq("rd_lat1", 64'(rsp_valid), 64'd1);
      check_eq("rd_done_early", 64'(cmd_done), 64'd0);
      check_eq("rd_no_wr", 64'(mem_wr_en), 64'd0);
      check_eq("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      if (mem_rd_en) begin
        issued++;
        check_eq("rd_addr", 64'(mem_rd_addr), 64'((a + issued - 1) % DEPTH));
      end
      if (rsp_valid) begin
        check_eq("rd_data", 64'(rsp_data), 64'(ref_mem[(a + got) % DEPTH]));
        if (prev_stall) check_eq("rd_stable", 64'(rsp_data), 64'(prev_data));
        if (!rsp_ready) check_eq("rd_stall_en", 64'(mem_rd_en), 64'd0);
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      if (rsp_valid && rsp_ready) got++;
      step(); cyc++;
    end
    rsp_ready = 1'b0;
    check_eq("rd_budget", 64'(cyc < 300), 64'd1);
    check_eq("rd_issued", 64'(issued), 64'(len + 1));
    settle();
    check_eq("rd_done", 64'(cmd_done), 64'd1);
    check_eq("rd_done_no_rsp", 64'(rsp_valid), 64'd0);
    check_eq("done_cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    settle(); check_eq("rd_done_pulse", 64'(cmd_done), 64'd0); step();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, len;
    bit exp_err;
    for (int i = 0; i < DEPTH; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
    mem_rd_q = '0; corrupt = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    settle();
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_outs", 64'({wdata_ready, rsp_valid, cmd_done, verify_err, mem_wr_en, mem_rd_en}), 64'd0);
    check_eq("rst_buses", 64'({mem_wr_addr, mem_rd_addr}) | 64'(rsp_data) | 64'(mem_wr_data), 64'd0);
    step();

    // Wrapping write, then reads with steady and toggling backpressure.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    do_write(6, 3, 1'b0, 1'b0, 0, 0);
    do_read(6, 3, 0, 1'b0);
    do_read(6, 3, 1, 1'b0);

    // Command held during a write burst is taken only once the burst is done.
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hB0 + i;
    do_write(1, 2, 1'b0, 1'b1, 1, 2);
    do_read(1, 2, 0, 1'b1);

    // Reset during beat 2 of a 4-beat read.
    accept(1'b0, 6, 3);
    rsp_ready = 1'b1;
    settle(); step();
    settle(); check_eq("rst_mid_beat1", 64'(rsp_data), 64'(ref_mem[6])); step();
    rst_n = 1'b0;
    settle(); step();
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    settle();
    check_eq("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rstmid_done", 64'(cmd_done), 64'd0);
    check_eq("rstmid_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AWIDTH'(0); cmd_len = AWIDTH'(1);
    step();
    cmd_valid = 1'b0;
    do_read(0, 1, 0, 1'b1);

    // Write-verify against a memory returning a corrupted read-back.
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    corrupt = 1;
    wbuf[0] = 32'h55;
    do_write(2, 0, 1'b0, 1'b0, 0, 0);
    corrupt = 0;
    settle(); check_eq("verify_err", 64'(verify_err), 64'(exp_err)); step();
    step(); step();
    settle(); check_eq("verify_err_held", 64'(verify_err), 64'(exp_err)); step();
    do_read(2, 0, 0, 1'b0);

    // Randomized bursts against the reference image.
    for (int n = 0; n < 25; n++) begin
      a = $urandom_range(DEPTH - 1);
      len = $urandom_range(DEPTH - 1);
      for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
      do_write(a, len, 1'b1, 1'b0, 0, 0);
      do_read($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1), 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
